// File: rtl/shift_serializer.sv
// Parallel-in, serial-out transmitter with IDLE/SHIFT/DONE framing.
// A word accepted in IDLE goes out one bit per cp cycle on sout. A single
// DONE cycle follows the last bit, then the block returns to IDLE.
// Every output comes straight from a flop, so no input reaches an output
// combinationally.
module shift_serializer #(
  parameter int WIDTH      = 4,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             cp,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic             sout,
  output logic             ready,
  output logic             busy,
  output logic             last,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_FIRST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;   // bits not yet sent, next one at the send end
  logic [CW-1:0]    cnt_q, cnt_d;       // bits remaining after the one on sout
  logic             sout_q, sout_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             last_q, last_d;
  logic             done_q, done_d;

  // Next-state and next-output decode.
  // The defaults are the IDLE outputs, so DONE and the unused code both fall back to IDLE.
  always_comb begin
    state_d = S_IDLE;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    sout_d  = IDLE_LEVEL;
    ready_d = 1'b1;
    busy_d  = 1'b0;
    last_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          // Put the first bit on sout now and keep the remaining bits queued in shreg.
          state_d = S_SHIFT;
          cnt_d   = CNT_FIRST;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          if (MSB_FIRST) begin
            sout_d  = din[WIDTH-1];
            shreg_d = {din[WIDTH-2:0], 1'b0};
          end else begin
            sout_d  = din[0];
            shreg_d = {1'b0, din[WIDTH-1:1]};
          end
        end
      end
      S_SHIFT: begin
        ready_d = 1'b0;
        if (cnt_q == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_SHIFT;
          busy_d  = 1'b1;
          cnt_d   = cnt_q - 1'b1;
          last_d  = (cnt_q == CW'(1));
          if (MSB_FIRST) begin
            sout_d  = shreg_q[WIDTH-1];
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          end else begin
            sout_d  = shreg_q[0];
            shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; an async reset drops any partial frame.
  always_ff @(posedge cp or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      sout_q  <= IDLE_LEVEL;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      sout_q  <= sout_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign sout  = sout_q;
  assign ready = ready_q;
  assign busy  = busy_q;
  assign last  = last_q;
  assign done  = done_q;

endmodule

// File: tb/tb_shift_serializer.sv
// Bench for shift_serializer. Two instances share the stimulus:
// an MSB-first one with idle level 0, and an LSB-first one with idle level 1.
// The expected outputs come from a per-frame timeline of records.
module tb_shift_serializer;

  localparam int W = 4;

  logic cp, reset, load;
  logic [W-1:0] din;
  logic sout_m, ready_m, busy_m, last_m, done_m;
  logic sout_l, ready_l, busy_l, last_l, done_l;
  logic [W-1:0] rx;

  int n_chk, n_fail, n_done;

  shift_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_m (
    .cp(cp), .reset(reset), .load(load), .din(din),
    .sout(sout_m), .ready(ready_m), .busy(busy_m), .last(last_m), .done(done_m));

  shift_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_l (
    .cp(cp), .reset(reset), .load(load), .din(din),
    .sout(sout_l), .ready(ready_l), .busy(busy_l), .last(last_l), .done(done_l));

  initial cp = 1'b0;
  always #5 cp = ~cp;

  // Loopback receiver: samples sout on each cp edge and shifts it toward the MSB.
  always @(posedge cp) rx <= {rx[W-2:0], sout_m};

  // Each record is {sout, ready, busy, last, done}.
  logic [4:0] q_m[$], q_l[$];
  logic [4:0] exp_m, exp_l;
  logic [W-1:0] word_m;

  function automatic logic [4:0] idle_rec(bit lvl);
    return {lvl, 1'b1, 1'b0, 1'b0, 1'b0};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One frame is W data cycles, then one DONE cycle, then one IDLE cycle
  // during which load is not yet looked at.
  task automatic push_frame(input bit msb, input bit lvl, input logic [W-1:0] w, inout logic [4:0] q[$]);
    for (int i = 0; i < W; i++) begin
      bit b;
      b = msb ? w[W-1-i] : w[i];
      q.push_back({b, 1'b0, 1'b1, (i == W-1), 1'b0});
    end
    q.push_back({lvl, 1'b0, 1'b0, 1'b0, 1'b1});
    q.push_back(idle_rec(lvl));
  endtask

  task automatic model_edge(input bit l, input logic [W-1:0] d);
    if (q_m.size() == 0 && l) begin
      push_frame(1'b1, 1'b0, d, q_m);
      word_m = d;
    end
    if (q_l.size() == 0 && l) push_frame(1'b0, 1'b1, d, q_l);
    exp_m = (q_m.size() > 0) ? q_m.pop_front() : idle_rec(1'b0);
    exp_l = (q_l.size() > 0) ? q_l.pop_front() : idle_rec(1'b1);
  endtask

  task automatic compare(input string tag);
    chk({tag, "_msb"}, {3'b0, sout_m, ready_m, busy_m, last_m, done_m}, {3'b0, exp_m});
    chk({tag, "_lsb"}, {3'b0, sout_l, ready_l, busy_l, last_l, done_l}, {3'b0, exp_l});
    if (exp_m[0]) chk({tag, "_loop"}, {4'b0, rx}, {4'b0, word_m});
    if (done_m) n_done++;
  endtask

  // Called at a negedge: take one cp edge, check #2 after it, then return at the next negedge.
  task automatic step(input string tag);
    @(posedge cp);
    model_edge(load, din);
    #2;
    compare(tag);
    @(negedge cp);
  endtask

  // Reset pulse between edges; the outputs must show the reset values before any cp edge.
  task automatic mid_reset(input string tag);
    #1 reset = 1'b1;
    #1;
    q_m.delete();
    q_l.delete();
    exp_m = idle_rec(1'b0);
    exp_l = idle_rec(1'b1);
    compare(tag);
    #1 reset = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_fail = 0; n_done = 0;
    reset = 1'b1; load = 1'b0; din = '0;
    exp_m = idle_rec(1'b0); exp_l = idle_rec(1'b1);
    #2 compare("reset");
    @(negedge cp) reset = 1'b0;
    step("idle");

    // Single frame of 1011: MSB-first sends 1,0,1,1; LSB-first sends 1,1,0,1.
    din = 4'b1011; load = 1'b1;
    step("f1011");
    load = 1'b0; din = 4'b0000;
    repeat (7) step("f1011");

    // load asserted during SHIFT and DONE is ignored.
    din = 4'b1100; load = 1'b1;
    step("ign");
    din = 4'b0011;
    repeat (W + 1) step("ign");
    load = 1'b0;
    repeat (3) step("ign");

    // Reset partway through a frame, after two bits have gone out.
    din = 4'b1010; load = 1'b1;
    step("rst");
    load = 1'b0;
    step("rst");
    mid_reset("rst_now");
    n_done = 0;
    repeat (8) step("rst_after");
    chk("rst_no_done", 8'(n_done), 8'd0);

    // load held high: a frame every W+2 cycles.
    din = 4'b0110; load = 1'b1;
    n_done = 0;
    repeat (3 * (W + 2)) step("hold");
    chk("hold_done_cnt", 8'(n_done), 8'd3);
    load = 1'b0;
    repeat (W + 2) step("hold");

    // Random traffic with an occasional reset.
    for (int i = 0; i < 400; i++) begin
      load = ($urandom_range(0, 2) == 0);
      din  = W'($urandom);
      if ($urandom_range(0, 60) == 0) mid_reset("rand_rst");
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Backstop so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
